// File: rtl/difftest_trap_gen.sv
// Difftest trap-event producer: counts cycles and commits, detects trap, WFI and
// commit-stall timeout, and feeds the trap-event sink with registered values.
module difftest_trap_gen #(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned TIMEOUT      = 5000,
    parameter logic [2:0]  TIMEOUT_CODE = 3'd3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              coreid,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic [63:0]             commit_pc,
    input  logic                    trap_valid,
    input  logic [2:0]              trap_code,
    input  logic [63:0]             trap_pc,
    input  logic                    wfi,
    output logic                    enable,
    output logic                    io_hasTrap,
    output logic [63:0]             io_cycleCnt,
    output logic [63:0]             io_instrCnt,
    output logic                    io_hasWFI,
    output logic [2:0]              io_code,
    output logic [63:0]             io_pc,
    output logic [7:0]              io_coreid,
    output logic                    halted
);
    // state     | meaning
    // ST_RUN    | counting commits/cycles, watching for trap or stall timeout
    // ST_REPORT | one cycle presenting the trap event to the sink
    // ST_HALT   | everything frozen until reset
    typedef enum logic [1:0] {ST_RUN, ST_REPORT, ST_HALT} state_t;

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int POP_W  = $clog2(COMMIT_WIDTH + 1);

    state_t              r_state;
    logic [63:0]         r_cycle_cnt;
    logic [63:0]         r_instr_cnt;
    logic [63:0]         r_last_pc;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic                r_enable;
    logic                r_has_trap;
    logic                r_has_wfi;
    logic [2:0]          r_code;
    logic [63:0]         r_pc;
    logic [7:0]          r_coreid;
    logic                r_halted;

    logic [POP_W-1:0]    w_popcnt;
    logic                w_any_commit;
    logic [63:0]         w_last_pc_nxt;
    logic                w_timeout;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            w_popcnt = w_popcnt + POP_W'(commit_valid[i]);
        end
    end

    assign w_any_commit  = |commit_valid;
    assign w_last_pc_nxt = w_any_commit ? commit_pc : r_last_pc;
    // A trap in the threshold cycle takes priority, hence the !trap_valid term.
    assign w_timeout     = !w_any_commit && !wfi && !trap_valid &&
                           (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_last_pc   <= '0;
            r_idle_cnt  <= '0;
            r_enable    <= 1'b0;
            r_has_trap  <= 1'b0;
            r_has_wfi   <= 1'b0;
            r_code      <= '0;
            r_pc        <= '0;
            r_coreid    <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 64'd1;
                    r_instr_cnt <= r_instr_cnt + 64'(w_popcnt);
                    r_last_pc   <= w_last_pc_nxt;
                    if (w_any_commit || wfi) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt != IDLE_W'(TIMEOUT)) begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    end
                    r_enable  <= 1'b1;
                    r_has_wfi <= wfi;
                    r_coreid  <= coreid;
                    if (trap_valid) begin
                        r_state    <= ST_REPORT;
                        r_has_trap <= 1'b1;
                        r_code     <= trap_code;
                        r_pc       <= trap_pc;
                    end else if (w_timeout) begin
                        r_state    <= ST_REPORT;
                        r_has_trap <= 1'b1;
                        r_code     <= TIMEOUT_CODE;
                        r_pc       <= r_last_pc;
                    end else begin
                        r_has_trap <= 1'b0;
                        r_code     <= '0;
                        r_pc       <= w_last_pc_nxt;
                    end
                end
                ST_REPORT: begin
                    r_state  <= ST_HALT;
                    r_enable <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_enable <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign enable      = r_enable;
    assign io_hasTrap  = r_has_trap;
    assign io_cycleCnt = r_cycle_cnt;
    assign io_instrCnt = r_instr_cnt;
    assign io_hasWFI   = r_has_wfi;
    assign io_code     = r_code;
    assign io_pc       = r_pc;
    assign io_coreid   = r_coreid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_difftest_trap_gen.sv
// Bench for difftest_trap_gen: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-count/commit-count reference model.
module tb_difftest_trap_gen;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  coreid = 8'h00;
    logic [1:0]  commit_valid = 2'b00;
    logic [63:0] commit_pc = 64'd0;
    logic        trap_valid = 1'b0;
    logic [2:0]  trap_code = 3'd0;
    logic [63:0] trap_pc = 64'd0;
    logic        wfi = 1'b0;
    logic        enable, io_hasTrap, io_hasWFI, halted;
    logic [63:0] io_cycleCnt, io_instrCnt, io_pc;
    logic [2:0]  io_code;
    logic [7:0]  io_coreid;

    difftest_trap_gen #(.COMMIT_WIDTH(2), .TIMEOUT(TO), .TIMEOUT_CODE(3'd3)) dut (
        .clock(clock), .reset(reset), .coreid(coreid),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
        .wfi(wfi), .enable(enable), .io_hasTrap(io_hasTrap),
        .io_cycleCnt(io_cycleCnt), .io_instrCnt(io_instrCnt),
        .io_hasWFI(io_hasWFI), .io_code(io_code), .io_pc(io_pc),
        .io_coreid(io_coreid), .halted(halted)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model: running totals plus "reported"/"stopped" flags.
    logic [63:0] m_cycle, m_instr, m_last_pc;
    logic [7:0]  m_coreid;
    int          m_quiet;
    bit          m_reported, m_stopped;
    logic        e_enable, e_hastrap, e_haswfi, e_halted;
    logic [2:0]  e_code;
    logic [63:0] e_pc;
    logic [7:0]  e_coreid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycle = '0; m_instr = '0; m_last_pc = '0; m_quiet = 0;
        m_reported = 0; m_stopped = 0;
        e_enable = 0; e_hastrap = 0; e_haswfi = 0; e_halted = 0;
        e_code = '0; e_pc = '0; e_coreid = '0;
    endtask

    task automatic model_edge(input logic [1:0] cv, input logic [63:0] pc, input logic tv,
                              input logic [2:0] tc, input logic [63:0] tpc, input logic w);
        bit quiet;
        if (m_stopped) return;
        if (m_reported) begin
            m_stopped = 1; e_enable = 0; e_halted = 1;
            return;
        end
        quiet = (cv == 2'b00) && !w;
        m_cycle = m_cycle + 64'd1;
        m_instr = m_instr + 64'($countones(cv));
        if (cv != 2'b00) m_last_pc = pc;
        e_enable = 1; e_haswfi = w; e_coreid = m_coreid;
        if (tv) begin
            m_reported = 1; e_hastrap = 1; e_code = tc; e_pc = tpc;
        end else if (quiet && m_quiet == TO - 1) begin
            m_reported = 1; e_hastrap = 1; e_code = 3'd3; e_pc = m_last_pc;
        end else begin
            e_hastrap = 0; e_code = 3'd0; e_pc = m_last_pc;
        end
        m_quiet = quiet ? m_quiet + 1 : 0;
    endtask

    task automatic check_all();
        chk("enable",   64'(enable),     64'(e_enable));
        chk("hasTrap",  64'(io_hasTrap), 64'(e_hastrap));
        chk("cycleCnt", io_cycleCnt,     m_cycle);
        chk("instrCnt", io_instrCnt,     m_instr);
        chk("hasWFI",   64'(io_hasWFI),  64'(e_haswfi));
        chk("code",     64'(io_code),    64'(e_code));
        chk("pc",       io_pc,           e_pc);
        chk("coreid",   64'(io_coreid),  64'(e_coreid));
        chk("halted",   64'(halted),     64'(e_halted));
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input logic [1:0] cv, input logic [63:0] pc, input logic tv,
                        input logic [2:0] tc, input logic [63:0] tpc, input logic w);
        commit_valid = cv; commit_pc = pc; trap_valid = tv;
        trap_code = tc; trap_pc = tpc; wfi = w;
        @(posedge clock);
        model_edge(cv, pc, tv, tc, tpc, w);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n, input logic w);
        for (int i = 0; i < n; i++) step(2'b00, 64'd0, 1'b0, 3'd0, 64'd0, w);
    endtask

    task automatic apply_reset(input logic [7:0] cid);
        @(negedge clock);
        reset = 1'b0; coreid = cid; m_coreid = cid;
        commit_valid = '0; trap_valid = 1'b0; wfi = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_random(input int n, input int p_commit, input int p_wfi, input int p_trap);
        logic [1:0] cv;
        logic       w, tv;
        for (int i = 0; i < n; i++) begin
            cv = ($urandom_range(99) < p_commit) ? 2'($urandom) : 2'b00;
            w  = ($urandom_range(99) < p_wfi);
            tv = ($urandom_range(999) < p_trap);
            step(cv, {$urandom, $urandom}, tv, 3'($urandom), {$urandom, $urandom}, w);
        end
    endtask

    initial begin
        apply_reset(8'h5A);
        idle(10, 1'b1);
        chk("wfi_run_cycle10", io_cycleCnt, 64'd10);

        apply_reset(8'h11);
        for (int i = 0; i < 5; i++) step(2'b11, 64'h8000_0000 + 64'(i * 8), 1'b0, 3'd0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b01, 64'h8000_0100 + 64'(i * 4), 1'b0, 3'd0, 64'd0, 1'b0);
        chk("instr13", io_instrCnt, 64'd13);

        apply_reset(8'h22);
        for (int i = 0; i < 7; i++) step(2'b01, 64'h8000_1000 + 64'(i * 4), 1'b0, 3'd0, 64'd0, 1'b0);
        step(2'b01, 64'h8000_1234, 1'b1, 3'd0, 64'h8000_1234, 1'b0);
        chk("trap_has", 64'(io_hasTrap), 64'd1);
        chk("trap_pc", io_pc, 64'h8000_1234);
        chk("trap_instr", io_instrCnt, 64'd8);
        chk("trap_enable", 64'(enable), 64'd1);
        run_random(20, 80, 30, 300);
        chk("halt_enable", 64'(enable), 64'd0);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_instr", io_instrCnt, 64'd8);
        chk("halt_cycle", io_cycleCnt, 64'd8);

        apply_reset(8'h33);
        step(2'b00, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0);
        chk("post_halt_cycle", io_cycleCnt, 64'd1);

        apply_reset(8'h44);
        step(2'b10, 64'h8000_0100, 1'b0, 3'd0, 64'd0, 1'b0);
        idle(TO - 1, 1'b0);
        chk("pre_timeout", 64'(io_hasTrap), 64'd0);
        idle(1, 1'b0);
        chk("timeout_has", 64'(io_hasTrap), 64'd1);
        chk("timeout_code", 64'(io_code), 64'd3);
        chk("timeout_pc", io_pc, 64'h8000_0100);
        idle(2, 1'b0);

        apply_reset(8'h55);
        step(2'b01, 64'h8000_0200, 1'b0, 3'd0, 64'd0, 1'b0);
        idle(100, 1'b1);
        chk("wfi_no_timeout", 64'(io_hasTrap), 64'd0);
        chk("wfi_not_halted", 64'(halted), 64'd0);

        apply_reset(8'h66);
        step(2'b01, 64'h8000_0300, 1'b0, 3'd0, 64'd0, 1'b0);
        idle(TO - 1, 1'b0);
        step(2'b00, 64'd0, 1'b1, 3'd5, 64'hDEAD_0040, 1'b0);
        chk("tie_code", 64'(io_code), 64'd5);
        chk("tie_pc", io_pc, 64'hDEAD_0040);
        idle(2, 1'b0);

        apply_reset(8'h77);
        step(2'b00, 64'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        force dut.r_cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_cycle_cnt;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFE;
        idle(3, 1'b1);
        chk("cycle_wrap", io_cycleCnt, 64'd1);

        apply_reset(8'h88); run_random(200, 50, 10, 5);
        apply_reset(8'h99); run_random(200, 5, 30, 2);
        apply_reset(8'hAA); run_random(200, 20, 5, 5);
        apply_reset(8'hBB); run_random(200, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/difftest_trap_gen.md
Name: difftest_trap_gen

Overview:
- Core-side producer for the difftest trap-event channel. Watches the commit stream, keeps cycle and instruction counters, detects trap instructions, WFI and commit-stall timeouts, and drives the trap-event sink with registered values.
- Sits in the core's difftest glue between the commit stage and the trap-event DPI sink.
- One instance per core.

Parameters:
- COMMIT_WIDTH, 2, number of commit lanes per cycle (1..8).
- TIMEOUT, 5000, consecutive no-commit cycles before a timeout trap is raised (>=2).
- TIMEOUT_CODE, 3'd3, trap code reported on a watchdog timeout.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- coreid  in  8  static core id; passed through registered.
- commit_valid  in  COMMIT_WIDTH  per-lane commit strobe; any bit pattern is legal.
- commit_pc  in  64  PC of the highest-index valid lane this cycle.
- trap_valid  in  1  trap instruction committed this cycle.
- trap_code  in  3  code carried by the trap instruction.
- trap_pc  in  64  PC of the trap instruction.
- wfi  in  1  core is stalled in WFI (level).
- enable  out  1  sink sample strobe.
- io_hasTrap  out  1  trap reported.
- io_cycleCnt  out  64  cycles since reset.
- io_instrCnt  out  64  committed instructions since reset.
- io_hasWFI  out  1  registered wfi.
- io_code  out  3  trap code.
- io_pc  out  64  trap PC, or last committed PC.
- io_coreid  out  8  registered coreid.
- halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = RUN.
  - All outputs 0, except io_coreid, which is sampled from the first clock after release.
  - cycle_cnt, instr_cnt, idle_cnt and last_pc all 0.
- Every io_* output and enable is a register. Each reflects the inputs of the previous cycle, so latency is 1 cycle.
- FSM has three states: RUN, REPORT, HALT.
- RUN:
  - cycle_cnt += 1 each cycle; 64-bit, wraps modulo 2^64.
  - instr_cnt += popcount(commit_valid); wraps modulo 2^64.
  - last_pc <= commit_pc when commit_valid != 0.
  - idle_cnt resets to 0 on any commit or while wfi = 1; otherwise it increments, saturating at TIMEOUT.
  - enable = 1 every cycle; io_hasTrap = 0; io_pc = last_pc; io_code = 0.
- RUN -> REPORT on trap_valid = 1:
  - Latch code = trap_code and pc = trap_pc.
  - Commits in the same cycle are counted, including the trap instruction's own lane.
- RUN -> REPORT on idle_cnt == TIMEOUT-1 with no commit, wfi = 0 and trap_valid = 0:
  - Latch code = TIMEOUT_CODE and pc = last_pc.
- Trap and timeout in the same cycle: the trap wins.
- REPORT (exactly 1 cycle):
  - Outputs present io_hasTrap = 1, the latched io_code and io_pc, enable = 1, and final counter values with cycle_cnt including the trap cycle.
  - Go to HALT.
- HALT:
  - enable = 0 and halted = 1.
  - All io_* outputs hold their REPORT values.
  - Counters frozen; commit_valid, trap_valid and wfi ignored.
  - Exit only via reset.
- Reset asserted in any state returns to RUN with counters cleared; no REPORT is emitted for an interrupted trap.
- io_hasWFI tracks wfi with 1-cycle delay in RUN; frozen in HALT.

Test Plan:
- Reset then 10 idle cycles with wfi = 1 -> enable = 1 from cycle 1, io_cycleCnt steps 1..10, io_instrCnt = 0, io_hasWFI = 1, no trap.
- COMMIT_WIDTH = 2, commit_valid = 2'b11 for 5 cycles then 2'b01 for 3 cycles -> io_instrCnt reaches 13 one cycle after the last commit.
- trap_valid with code 3'd0 at pc 0x8000_1234 and commit_valid = 2'b01, after 7 prior commits -> one cycle with io_hasTrap = 1, io_code = 0, io_pc = 0x8000_1234, io_instrCnt = 8, enable = 1; then enable = 0, halted = 1, outputs held for 20 cycles despite further commits and traps.
- TIMEOUT = 16, last commit at pc 0x8000_0100 then no commits and wfi = 0 -> REPORT on the 16th idle cycle with io_code = 3, io_pc = 0x8000_0100. Repeat with wfi = 1 for 100 cycles -> no timeout.
- trap_valid in the same cycle as the timeout threshold -> io_code = trap_code, io_pc = trap_pc.
- Preload cycle_cnt near 2^64-1 via force, run 3 cycles -> wraps to 1. Assert reset during HALT -> all outputs 0 and state RUN, then counting resumes from 0.
